// File: rtl/pht_sched.sv
// Port arbiter, pending-update FIFO and global history for the PHT.
// Define PHT_SCHED_GSHARE_EN for gshare indexing; bimodal otherwise.
module pht_sched #(
    parameter int ADDR_W     = 8,
    parameter int HIST_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lk_valid,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_ready,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_index,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_index,
    input  logic              upd_taken,
    output logic              upd_ready,
    output logic [ADDR_W-1:0] pht_addr,
    output logic              pht_request,
    output logic              pht_result,
    output logic              pht_taken,
    input  logic              pht_prediction,
    output logic [HIST_W-1:0] ghr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_LOOKUP,
        SLOT_UPDATE
    } slot_e;

    logic [ADDR_W-1:0] fifo_idx [FIFO_DEPTH];
    logic              fifo_tk  [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ST_W-1:0]   starve;

    logic              full;
    logic              empty;
    logic              starve_hit;
    logic              push;
    logic              pop;
    slot_e             slot;
    logic [ADDR_W-1:0] lk_index;
    logic [ADDR_W-1:0] head_idx;
    logic              head_tk;
    logic [HIST_W-1:0] ghr_shift;

    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign starve_hit = (starve == ST_W'(STARVE_MAX));
    assign head_idx   = fifo_idx[rd_ptr];
    assign head_tk    = fifo_tk[rd_ptr];
    assign ghr_shift  = (ghr << 1) | HIST_W'(upd_taken);

`ifdef PHT_SCHED_GSHARE_EN
    assign lk_index = lk_pc ^ ADDR_W'(ghr);
`else
    assign lk_index = lk_pc;
`endif

    // Training wins when the FIFO is full, the fetch side has hogged the
    // port long enough, or the port would otherwise sit idle.
    always_comb begin
        slot = SLOT_IDLE;
        if (full || (!empty && (starve_hit || !lk_valid))) begin
            slot = SLOT_UPDATE;
        end else if (lk_valid) begin
            slot = SLOT_LOOKUP;
        end
    end

    assign lk_ready  = (slot != SLOT_UPDATE);
    assign upd_ready = !full;
    assign push      = upd_valid && !full;
    assign pop       = (slot == SLOT_UPDATE);

    always_comb begin
        pht_addr    = '0;
        pht_request = 1'b0;
        pht_result  = 1'b0;
        pht_taken   = 1'b0;
        if (!rst) begin
            unique case (slot)
                SLOT_LOOKUP: begin
                    pht_addr    = lk_index;
                    pht_request = 1'b1;
                end
                SLOT_UPDATE: begin
                    pht_addr   = head_idx;
                    pht_result = 1'b1;
                    pht_taken  = head_tk;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_idx[wr_ptr] <= upd_index;
            fifo_tk[wr_ptr]  <= upd_taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ghr    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                ghr    <= ghr_shift;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= '0;
        end else if (pop || empty) begin
            starve <= '0;
        end else if (slot == SLOT_LOOKUP && !starve_hit) begin
            starve <= starve + ST_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_index <= '0;
        end else if (slot == SLOT_LOOKUP) begin
            pred_valid <= 1'b1;
            pred_taken <= pht_prediction;
            pred_index <= lk_index;
        end else begin
            pred_valid <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    a_no_train_empty: assert property (
        @(posedge clk) disable iff (rst) pht_result |-> !empty);
    a_count_range: assert property (
        @(posedge clk) disable iff (rst) count <= CNT_W'(FIFO_DEPTH));
    a_one_strobe: assert property (
        @(posedge clk) disable iff (rst) !(pht_request && pht_result));
`endif

endmodule

// File: tb/tb_pht_sched.sv
// Self-checking bench for pht_sched: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_pht_sched;

    localparam int ADDR_W     = 8;
    localparam int HIST_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              lk_valid = 1'b0;
    logic [ADDR_W-1:0] lk_pc = '0;
    logic              lk_ready;
    logic              pred_valid;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_index;
    logic              upd_valid = 1'b0;
    logic [ADDR_W-1:0] upd_index = '0;
    logic              upd_taken = 1'b0;
    logic              upd_ready;
    logic [ADDR_W-1:0] pht_addr;
    logic              pht_request;
    logic              pht_result;
    logic              pht_taken;
    logic              pht_prediction;
    logic [HIST_W-1:0] ghr;

    logic tbl [256];
    int   n_checks = 0;
    int   n_fail   = 0;

    assign pht_prediction = tbl[pht_addr];

    always #5 clk = ~clk;

    pht_sched #(
        .ADDR_W(ADDR_W), .HIST_W(HIST_W),
        .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_ready(lk_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_index(pred_index),
        .upd_valid(upd_valid), .upd_index(upd_index),
        .upd_taken(upd_taken), .upd_ready(upd_ready),
        .pht_addr(pht_addr), .pht_request(pht_request),
        .pht_result(pht_result), .pht_taken(pht_taken),
        .pht_prediction(pht_prediction), .ghr(ghr)
    );

    function automatic logic [7:0] idx_of(logic [7:0] pc, logic [7:0] h);
`ifdef PHT_SCHED_GSHARE_EN
        return pc ^ h;
`else
        return pc;
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        lk_valid  = 1'b0;
        upd_valid = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (pred_valid !== 1'b0 || ghr !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: pv=%b ghr=%h want 0/00", pred_valid, ghr);
        end
        n_checks++;
        if (upd_ready !== 1'b1 || pht_result !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ports: urdy=%b res=%b want 1/0", upd_ready, pht_result);
        end
        cyc();
        lk_valid = 1'b1; lk_pc = 8'h05;
        upd_valid = 1'b1; upd_index = 8'h21; upd_taken = 1'b1;
        cyc();
        upd_index = 8'h22;
        cyc();
        upd_valid = 1'b0;
        lk_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (pred_valid !== 1'b0 || ghr !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_regs: pv=%b ghr=%h want 0/00", pred_valid, ghr);
        end
        n_checks++;
        if (pht_result !== 1'b0 || pht_request !== 1'b0 || pht_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_pht: res=%b req=%b addr=%h want 0/0/00",
                     pht_result, pht_request, pht_addr);
        end
        cyc();
        #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (pht_result !== 1'b0 || upd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL postreset_empty[%0d]: res=%b urdy=%b want 0/1",
                         i, pht_result, upd_ready);
            end
        end
    endtask

    task automatic test_lookup();
        logic [7:0] e;
        do_reset();
        e = idx_of(8'h3C, ghr);
        tbl[e] = 1'b1;
        lk_valid = 1'b1; lk_pc = 8'h3C;
        #1;
        n_checks++;
        if (lk_ready !== 1'b1 || pht_request !== 1'b1 || pht_addr !== e) begin
            n_fail++;
            $display("FAIL lookup_port: rdy=%b req=%b addr=%h want 1/1/%h",
                     lk_ready, pht_request, pht_addr, e);
        end
        cyc();
        lk_valid = 1'b0;
        n_checks++;
        if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || pred_index !== e) begin
            n_fail++;
            $display("FAIL lookup_pred: pv=%b pt=%b pi=%h want 1/1/%h",
                     pred_valid, pred_taken, pred_index, e);
        end
        cyc();
        n_checks++;
        if (pred_valid !== 1'b0 || pred_index !== e || pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL lookup_hold: pv=%b pt=%b pi=%h want 0/1/%h",
                     pred_valid, pred_taken, pred_index, e);
        end
    endtask

    task automatic test_update();
        do_reset();
        upd_valid = 1'b1; upd_index = 8'h10; upd_taken = 1'b1;
        #1;
        n_checks++;
        if (pht_result !== 1'b0) begin
            n_fail++;
            $display("FAIL update_bypass: res=%b want 0", pht_result);
        end
        cyc();
        upd_valid = 1'b0;
        #1;
        n_checks++;
        if (pht_addr !== 8'h10 || pht_result !== 1'b1 || pht_taken !== 1'b1
            || pht_request !== 1'b0) begin
            n_fail++;
            $display("FAIL update_port: addr=%h res=%b tk=%b req=%b want 10/1/1/0",
                     pht_addr, pht_result, pht_taken, pht_request);
        end
        n_checks++;
        if (ghr !== 8'h01) begin
            n_fail++;
            $display("FAIL update_ghr: ghr=%h want 01", ghr);
        end
        cyc();
        n_checks++;
        if (pht_result !== 1'b0) begin
            n_fail++;
            $display("FAIL update_once: res=%b want 0", pht_result);
        end
    endtask

    task automatic test_starve();
        int acc;
        do_reset();
        lk_valid = 1'b1; lk_pc = 8'h47;
        upd_valid = 1'b1; upd_index = 8'h55; upd_taken = 1'b0;
        #1;
        n_checks++;
        if (lk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_first: rdy=%b want 1", lk_ready);
        end
        cyc();
        upd_valid = 1'b0;
        acc = 0;
        for (int i = 0; i < STARVE_MAX; i++) begin
            lk_pc = 8'($urandom);
            #1;
            if (lk_ready === 1'b1 && pht_request === 1'b1) acc++;
            cyc();
        end
        n_checks++;
        if (acc != STARVE_MAX) begin
            n_fail++;
            $display("FAIL starve_accepts: got %0d want %0d", acc, STARVE_MAX);
        end
        #1;
        n_checks++;
        if (lk_ready !== 1'b0 || pht_result !== 1'b1 || pht_addr !== 8'h55) begin
            n_fail++;
            $display("FAIL starve_forced: rdy=%b res=%b addr=%h want 0/1/55",
                     lk_ready, pht_result, pht_addr);
        end
        cyc();
        #1;
        n_checks++;
        if (lk_ready !== 1'b1 || pht_result !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_resume: rdy=%b res=%b want 1/0", lk_ready, pht_result);
        end
        cyc();
        lk_valid = 1'b0;
    endtask

    task automatic test_full();
        int rdy_ok;
        do_reset();
        lk_valid = 1'b1;
        rdy_ok = 0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            upd_valid = 1'b1;
            upd_index = 8'(8'h80 + i);
            upd_taken = 1'(i);
            lk_pc = 8'($urandom);
            #1;
            if (upd_ready === 1'b1) rdy_ok++;
            cyc();
        end
        n_checks++;
        if (rdy_ok != FIFO_DEPTH) begin
            n_fail++;
            $display("FAIL full_fill: ready %0d of %0d", rdy_ok, FIFO_DEPTH);
        end
        upd_index = 8'hEE;
        #1;
        n_checks++;
        if (upd_ready !== 1'b0 || lk_ready !== 1'b0 || pht_result !== 1'b1
            || pht_addr !== 8'h80) begin
            n_fail++;
            $display("FAIL full_slot: urdy=%b lrdy=%b res=%b addr=%h want 0/0/1/80",
                     upd_ready, lk_ready, pht_result, pht_addr);
        end
        n_checks++;
        if (ghr !== 8'h05) begin
            n_fail++;
            $display("FAIL full_ghr: ghr=%h want 05", ghr);
        end
        cyc();
        upd_valid = 1'b0;
        #1;
        n_checks++;
        if (upd_ready !== 1'b1 || lk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_release: urdy=%b lrdy=%b want 1/1", upd_ready, lk_ready);
        end
        cyc();
        lk_valid = 1'b0;
        for (int j = 1; j < FIFO_DEPTH; j++) begin
            #1;
            n_checks++;
            if (pht_result !== 1'b1 || pht_addr !== 8'(8'h80 + j)) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: res=%b addr=%h want 1/%h",
                         j, pht_result, pht_addr, 8'(8'h80 + j));
            end
            cyc();
        end
        #1;
        n_checks++;
        if (pht_result !== 1'b0) begin
            n_fail++;
            $display("FAIL full_dropped: res=%b addr=%h want 0", pht_result, pht_addr);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        lk_valid = 1'b1;
        upd_valid = 1'b1; upd_index = 8'h11; upd_taken = 1'b1;
        cyc();
        upd_index = 8'h22; upd_taken = 1'b0;
        cyc();
        lk_valid = 1'b0;
        upd_index = 8'h33; upd_taken = 1'b1;
        #1;
        n_checks++;
        if (pht_result !== 1'b1 || pht_addr !== 8'h11 || upd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pp_slot: res=%b addr=%h urdy=%b want 1/11/1",
                     pht_result, pht_addr, upd_ready);
        end
        cyc();
        upd_valid = 1'b0;
        n_checks++;
        if (ghr !== 8'h05) begin
            n_fail++;
            $display("FAIL pp_ghr: ghr=%h want 05", ghr);
        end
        #1;
        n_checks++;
        if (pht_result !== 1'b1 || pht_addr !== 8'h22) begin
            n_fail++;
            $display("FAIL pp_second: res=%b addr=%h want 1/22", pht_result, pht_addr);
        end
        cyc();
        n_checks++;
        if (pht_result !== 1'b1 || pht_addr !== 8'h33 || pht_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL pp_third: res=%b addr=%h tk=%b want 1/33/1",
                     pht_result, pht_addr, pht_taken);
        end
        cyc();
        n_checks++;
        if (pht_result !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_empty: res=%b want 0", pht_result);
        end
    endtask

    task automatic test_random();
        logic [7:0] qi [$];
        logic       qt [$];
        int         m_starve;
        logic [7:0] m_ghr;
        logic       m_pv;
        logic       m_pt;
        logic [7:0] m_pi;
        logic       full;
        logic       empty;
        logic       u_slot;
        logic       l_slot;
        logic [7:0] e_addr;
        int         bad;
        do_reset();
        m_starve = 0; m_ghr = '0; m_pv = 0; m_pt = 0; m_pi = '0;
        bad = 0;
        for (int n = 0; n < 3000; n++) begin
            lk_valid  = ($urandom_range(0, 9) < 7);
            lk_pc     = 8'($urandom);
            upd_valid = 1'($urandom);
            upd_index = 8'($urandom);
            upd_taken = 1'($urandom);
            #1;
            full   = (qi.size() == FIFO_DEPTH);
            empty  = (qi.size() == 0);
            u_slot = full || (!empty && (m_starve == STARVE_MAX || !lk_valid));
            l_slot = !u_slot && lk_valid;
            e_addr = u_slot ? qi[0] : idx_of(lk_pc, m_ghr);
            n_checks++;
            if (lk_ready !== !u_slot || upd_ready !== !full
                || pht_request !== l_slot || pht_result !== u_slot) begin
                n_fail++;
                $display("FAIL rnd_ctrl@%0d: lr=%b ur=%b req=%b res=%b want %b/%b/%b/%b",
                         n, lk_ready, upd_ready, pht_request, pht_result,
                         !u_slot, !full, l_slot, u_slot);
            end
            if (u_slot || l_slot) begin
                n_checks++;
                if (pht_addr !== e_addr || (u_slot && pht_taken !== qt[0])) begin
                    n_fail++;
                    $display("FAIL rnd_addr@%0d: addr=%h tk=%b want %h", n,
                             pht_addr, pht_taken, e_addr);
                end
            end
            if (l_slot) begin
                m_pv = 1'b1; m_pt = tbl[e_addr]; m_pi = e_addr;
            end else begin
                m_pv = 1'b0;
            end
            if (u_slot || empty) m_starve = 0;
            else if (l_slot && m_starve < STARVE_MAX) m_starve++;
            if (u_slot) begin
                void'(qi.pop_front());
                void'(qt.pop_front());
            end
            if (upd_valid && !full) begin
                qi.push_back(upd_index);
                qt.push_back(upd_taken);
                m_ghr = {m_ghr[6:0], upd_taken};
            end
            cyc();
            n_checks++;
            if (pred_valid !== m_pv || pred_taken !== m_pt
                || pred_index !== m_pi || ghr !== m_ghr) begin
                n_fail++;
                bad++;
                $display("FAIL rnd_pred@%0d: pv=%b pt=%b pi=%h ghr=%h want %b/%b/%h/%h",
                         n, pred_valid, pred_taken, pred_index, ghr,
                         m_pv, m_pt, m_pi, m_ghr);
                if (bad > 20) break;
            end
        end
        lk_valid = 1'b0;
        upd_valid = 1'b0;
    endtask

    initial begin
        foreach (tbl[i]) tbl[i] = 1'($urandom);
        test_reset();
        test_lookup();
        test_update();
        test_starve();
        test_full();
        test_push_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pht_sched.md
Name: pht_sched

Overview:
- Controller and arbiter in front of the 256-entry pattern history table (8-bit address, request/result/taken/prediction port).
- Shares the table's single address port between two requesters: the fetch-side lookup stream and the resolve-side training stream.
- Buffers resolved outcomes in a small FIFO and maintains the global history register.
- Forms the table index, bimodal or gshare.

Parameters:
- ADDR_W, 8, PHT index width; must equal the table address width.
- HIST_W, 8, global history length; 1..ADDR_W; right-aligned when XORed with the PC.
- FIFO_DEPTH, 4, pending-update FIFO entries; power of two, at least 2.
- STARVE_MAX, 8, consecutive lookup wins allowed while the FIFO is non-empty before one update slot is forced.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- lk_valid  in  1  lookup request.
- lk_pc  in  ADDR_W  low PC bits of the branch.
- lk_ready  out  1  lookup accepted this cycle; combinational.
- pred_valid  out  1  prediction valid; registered.
- pred_taken  out  1  predicted direction.
- pred_index  out  ADDR_W  table index used; the pipeline returns it with the update.
- upd_valid  in  1  resolved branch.
- upd_index  in  ADDR_W  index from pred_index.
- upd_taken  in  1  actual outcome.
- upd_ready  out  1  equals not FIFO full.
- pht_addr  out  ADDR_W  table address.
- pht_request  out  1  table lookup strobe.
- pht_result  out  1  table training strobe.
- pht_taken  out  1  training outcome.
- pht_prediction  in  1  table read data; combinational from pht_addr.
- ghr  out  HIST_W  current global history.

Behaviour:
- Reset (async, rst=1): pred_valid=0, pred_taken=0, pred_index=0, ghr=0, FIFO empty, starve counter=0. All pht_* outputs are 0 while in reset. A pending lookup or update is dropped; no table write occurs on that edge.
- Slot selection each cycle (combinational), one slot only:
  - UPDATE if FIFO full, or starve==STARVE_MAX, or (FIFO non-empty and lk_valid=0).
  - Otherwise LOOKUP if lk_valid=1.
  - Otherwise IDLE.
- lk_ready = (slot != UPDATE).
- LOOKUP slot: pht_addr = index(lk_pc), pht_request=1, pht_result=0.
  - At the clock edge: pred_valid<=1, pred_taken<=pht_prediction, pred_index<=pht_addr.
  - Latency is 1 cycle from acceptance to pred_valid.
- UPDATE slot: pht_addr=FIFO head index, pht_taken=head taken, pht_result=1, pht_request=0. Head pops at the edge.
- pred_valid is high exactly one cycle per accepted lookup. When no lookup is accepted it drops to 0, and pred_taken/pred_index hold their values.
- FIFO push when upd_valid && upd_ready. Push and pop in the same cycle are both performed; count is unchanged.
  - No bypass: an update pushed into an empty FIFO is written to the table no earlier than the next cycle.
- GHR: on push, ghr <= {ghr[HIST_W-2:0], upd_taken}. Non-speculative, in resolve order.
- Starve counter:
  - +1 (saturating at STARVE_MAX) on each LOOKUP slot while the FIFO is non-empty.
  - Clears on any UPDATE slot or when the FIFO is empty.
  - When it reaches STARVE_MAX, the next cycle is forced UPDATE even if lk_valid=1; lk_ready=0 that cycle.
- Full: upd_ready=0. A pop that cycle does not raise upd_ready until the next cycle.
- Empty: no UPDATE slot; pht_result=0.
- Pointers wrap modulo FIFO_DEPTH. Count is held in log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro PHT_SCHED_GSHARE_EN.
- Defined: index = lk_pc XOR zero-extended ghr (gshare).
- Undefined: index = lk_pc (bimodal). The GHR register is still maintained and output, but is not used for indexing.

Test Plan:
- Reset with FIFO holding 2 entries, rst pulsed mid-cycle -> FIFO empty, ghr=0, pred_valid=0 immediately; no pht_result pulse after release.
- lk_valid=1, lk_pc=8'h3C, table entry predicts taken, FIFO empty -> lk_ready=1; next cycle pred_valid=1, pred_taken=1, pred_index=8'h3C (bimodal) or 8'h3C^ghr (gshare).
- Push upd_index=8'h10, upd_taken=1 with lk_valid=0 -> next cycle pht_addr=8'h10, pht_result=1, pht_taken=1; ghr becomes 8'h01.
- lk_valid held high with 1 FIFO entry, STARVE_MAX=8 -> 8 lookups accepted, 9th cycle lk_ready=0 with UPDATE slot, then lookups resume.
- 4 pushes with lk_valid=1 and STARVE_MAX large -> upd_ready=0 after the 4th push; the next cycle is UPDATE; upd_ready=1 one cycle after the pop.
- Push and pop in the same cycle with count=2 -> count stays 2; ghr shifts in upd_taken.
